// File: rtl/wr_ptr_gray_full.sv
// ---------------------------------------------------------------------------
// wr_ptr_gray_full
//
// Write-side pointer and flag logic for an asynchronous FIFO. Everything here
// runs in the write clock domain. The block keeps a binary write pointer and a
// registered Gray copy of it for the read-domain synchronizer. It drives the
// memory write address and enable. It also produces the registered full and
// almost-full flags and a sticky overflow flag.
//
// Parameters
//   pointer_width : pointer width including the wrap bit (>= 3).
//                   FIFO depth is 2**(pointer_width-1).
//
// Ports
//   wclk         in  : write clock, rising edge
//   wrst_n       in  : asynchronous active-low reset
//   winc         in  : write request this cycle
//   wq2_rptr     in  : Gray read pointer, already synchronized into wclk
//   wfull        out : FIFO full (registered)
//   walmost_full out : occupancy >= depth-1 (registered)
//   woverflow    out : sticky, set by a write attempted while full
//   wclken       out : memory write enable (winc & ~wfull)
//   waddr        out : memory write address (low bits of binary pointer)
//   gray_wptr    out : registered Gray write pointer for the read domain
// ---------------------------------------------------------------------------
module wr_ptr_gray_full #(
  parameter int pointer_width = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic                     winc,
  input  logic [pointer_width-1:0] wq2_rptr,
  output logic                     wfull,
  output logic                     walmost_full,
  output logic                     woverflow,
  output logic                     wclken,
  output logic [pointer_width-2:0] waddr,
  output logic [pointer_width-1:0] gray_wptr
);

  localparam int DEPTH = 2 ** (pointer_width - 1);
  localparam logic [pointer_width-1:0] AFULL_LVL = pointer_width'(DEPTH - 1);

  logic [pointer_width-1:0] wbin_q, wbin_d;
  logic [pointer_width-1:0] wgray_q, wgray_d;
  logic                     wfull_q, wfull_d;
  logic                     walmost_full_q, walmost_full_d;
  logic                     woverflow_q, woverflow_d;
  logic [pointer_width-1:0] rbin_s;
  logic [pointer_width-1:0] occ_d;
  logic [pointer_width-1:0] full_pattern;

  // Gray-to-binary of the synchronized read pointer: each binary bit is the
  // XOR of all Gray bits from the MSB down to that position.
  for (genvar gi = 0; gi < pointer_width; gi++) begin : g_g2b
    assign rbin_s[gi] = ^wq2_rptr[pointer_width-1:gi];
  end

  // The write pointer is exactly one lap ahead of the read pointer when full.
  // In Gray code that is the read pointer with its two MSBs inverted.
  assign full_pattern = {~wq2_rptr[pointer_width-1], ~wq2_rptr[pointer_width-2],
                         wq2_rptr[pointer_width-3:0]};

  always_comb begin
    wclken         = winc & ~wfull_q;
    wbin_d         = wbin_q + {{(pointer_width-1){1'b0}}, wclken};
    wgray_d        = wbin_d ^ (wbin_d >> 1);
    // Flags use the post-write pointer, so the write that fills the last
    // slot raises wfull on the same edge.
    wfull_d        = (wgray_d == full_pattern);
    occ_d          = wbin_d - rbin_s;
    walmost_full_d = (occ_d >= AFULL_LVL);
    woverflow_d    = woverflow_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign woverflow    = woverflow_q;
  assign waddr        = wbin_q[pointer_width-2:0];
  // Straight from a flop so the value crossing domains never glitches.
  assign gray_wptr    = wgray_q;

endmodule

// File: tb/tb_wr_ptr_gray_full.sv
// Testbench for wr_ptr_gray_full. The reference model counts accepted writes
// and read-side pops as plain integers. Flags are derived from their
// difference. Expectations are queued per clock edge and a monitor compares
// them against the DUT just after each edge.
module tb_wr_ptr_gray_full;

  localparam int W     = 4;
  localparam int DEPTH = 2 ** (W - 1);

  logic         wclk = 1'b0;
  logic         wrst_n = 1'b0;
  logic         winc = 1'b0;
  logic [W-1:0] wq2_rptr = '0;
  logic         wfull, walmost_full, woverflow, wclken;
  logic [W-2:0] waddr;
  logic [W-1:0] gray_wptr;

  wr_ptr_gray_full #(.pointer_width(W)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .woverflow    (woverflow),
    .wclken       (wclken),
    .waddr        (waddr),
    .gray_wptr    (gray_wptr)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [W-2:0] addr;
    logic [W-1:0] gray;
    logic         full;
    logic         afull;
    logic         ovf;
    logic         clken;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: plain counts, no wrap arithmetic needed.
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;
  int   hist[$];

  function automatic logic [W-1:0] to_gray(input int unsigned n);
    logic [W-1:0] b;
    b = W'(n % (2 ** W));
    return b ^ (b >> 1);
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    cmp({tag, ".waddr"},        int'(waddr),        int'(e.addr));
    cmp({tag, ".gray_wptr"},    int'(gray_wptr),    int'(e.gray));
    cmp({tag, ".wfull"},        int'(wfull),        int'(e.full));
    cmp({tag, ".walmost_full"}, int'(walmost_full), int'(e.afull));
    cmp({tag, ".woverflow"},    int'(woverflow),    int'(e.ovf));
    cmp({tag, ".wclken"},       int'(wclken),       int'(e.clken));
  endtask

  // Model of one clock edge, using the inputs that were present at it.
  task automatic model_edge();
    exp_t e;
    int   occ;
    if (winc && m_full) m_ovf = 1'b1;
    if (winc && !m_full) wr_cnt++;
    occ     = wr_cnt - rd_cnt;
    m_full  = (occ == DEPTH);
    e.addr  = (W-1)'(wr_cnt % DEPTH);
    e.gray  = to_gray(wr_cnt);
    e.full  = m_full;
    e.afull = (occ >= DEPTH - 1);
    e.ovf   = m_ovf;
    e.clken = winc && !m_full;
    exp_q.push_back(e);
    hist.push_front(wr_cnt);
    if (hist.size() > 3) void'(hist.pop_back());
    $display("edge t=%0t winc=%0b wr=%0d rd=%0d occ=%0d full=%0b af=%0b ovf=%0b",
             $time, winc, wr_cnt, rd_cnt, occ, e.full, e.afull, e.ovf);
  endtask

  // mode 0: read pointer holds, 1: advance one pop, 2: track writes 2 edges late
  task automatic step(input logic w, input int mode);
    @(negedge wclk);
    winc = w;
    if (mode == 1 && rd_cnt < wr_cnt) rd_cnt++;
    else if (mode == 2 && hist.size() > 1 && hist[1] > rd_cnt) rd_cnt = hist[1];
    wq2_rptr = to_gray(rd_cnt);
    @(posedge wclk);
    model_edge();
  endtask

  task automatic do_reset(input string tag);
    exp_t z;
    @(negedge wclk);
    wrst_n   = 1'b0;
    winc     = 1'b0;
    rd_cnt   = 0;
    wq2_rptr = '0;
    #1;
    // Reset is asynchronous: outputs must already be zero with no clock edge.
    z = '0;
    check_all(tag, z);
    wr_cnt = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    hist.delete();
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // Monitor: compare the queued expectation just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all("mon", e);
      end
    end
  end

  initial begin
    do_reset("reset_init");

    // Five writes, then reset mid-stream; first write afterwards uses addr 0.
    repeat (5) step(1'b1, 0);
    do_reset("reset_mid");
    step(1'b1, 0);
    do_reset("reset_clr");

    // Fill to full, then three rejected writes (overflow, sticky).
    repeat (DEPTH) step(1'b1, 0);
    repeat (3) step(1'b1, 0);
    // Drain release: one pop drops wfull, next write lands at address 0.
    step(1'b0, 1);
    step(1'b1, 0);
    do_reset("reset_ovf");

    // Occupancy DEPTH-1, then write and pop on the same edge.
    repeat (DEPTH - 1) step(1'b1, 0);
    step(1'b1, 1);
    step(1'b0, 0);
    do_reset("reset_sim");

    // Streaming wrap with the read pointer lagging two edges.
    repeat (40) step(1'b1, 2);
    do_reset("reset_wrap");

    // Randomized mix of writes and pops.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, (($urandom % 3) == 0) ? 1 : 0);
    end

    repeat (2) @(negedge wclk);
    cmp("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wr_ptr_gray_full.md
# wr_ptr_gray_full

Write-side pointer and full-flag logic for the asynchronous FIFO, running entirely in the write clock domain. It does four things:
- keeps a binary write pointer and its registered Gray-coded copy, which is passed to the read domain through a 2-flop synchronizer;
- drives the memory write address and write enable;
- produces a registered full flag by comparing the next Gray pointer with the read pointer synchronized into this domain;
- adds a registered almost-full flag and a sticky overflow flag.

## Interface
- `pointer_width`, default 4: pointer width including the wrap bit. FIFO depth is DEPTH = 2^(pointer_width-1). Legal range is pointer_width ≥ 3.
- `wclk` input 1: write clock, rising-edge active.
- `wrst_n` input 1: write-domain reset, asynchronous assert, active-low.
- `winc` input 1: write request for this cycle.
- `wq2_rptr` input pointer_width: Gray read pointer, already 2-flop synchronized into wclk.
- `wfull` output 1: FIFO full, registered.
- `walmost_full` output 1: occupancy ≥ DEPTH-1, registered.
- `woverflow` output 1: sticky; set when a write is attempted while full.
- `wclken` output 1: memory write enable; combinational `winc & ~wfull`.
- `waddr` output pointer_width-1: memory write address, equal to wbin[pointer_width-2:0].
- `gray_wptr` output pointer_width: registered Gray write pointer, sent to the read-domain synchronizer.

One clock; reset is asynchronous and active-low (`wclk`, `wrst_n`).

## Operation
- Write acceptance: a write is accepted when `winc=1` and `wfull=0`.
  - `wclken` = `winc & ~wfull`.
  - wbin_next = wbin + `wclken`, modulo 2^pointer_width.
- Gray conversion: wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both `wbin` and `gray_wptr` load on every edge.
  - `gray_wptr` is a flop output, never combinational, so it is glitch-free for CDC.
- Full compare: `wfull` is loaded with (wgray_next == {~wq2_rptr[W-1], ~wq2_rptr[W-2], wq2_rptr[W-3:0]}), where W = pointer_width.
- Read-pointer decode: rbin_s = Gray-to-binary of `wq2_rptr` (prefix XOR from the MSB).
- Occupancy and almost-full:
  - occ_next = (wbin_next - rbin_s) mod 2^W, which lies in 0..DEPTH.
  - `walmost_full` is loaded with (occ_next ≥ DEPTH-1).
- Overflow:
  - `woverflow` is set on any edge where `winc=1` and `wfull=1`.
  - It is cleared only by reset.
  - The rejected write leaves the pointer, address and memory unchanged.
- Pessimism: the read pointer is seen late, so `wfull` and `walmost_full` deassert 2+ wclk cycles after the read-side pop. This is intentional and never causes an overflow.
- Wrap-around:
  - The pointer wraps from 2^W-1 to 0.
  - Gray wraps from the pattern 100…0 back to 0…0.
  - `waddr` wraps from DEPTH-1 to 0 every DEPTH accepted writes.

## Timing
- Reset values: `wbin`=0, `gray_wptr`=0, `waddr`=0, `wfull`=0, `walmost_full`=0, `woverflow`=0.
  - Reset takes effect immediately and asynchronously, including mid-write.
  - Release is synchronous to `wclk`; the first edge after release may accept a write.
- Write latency:
  - The write with `winc=1`, `wfull=0` at edge N is committed to memory at edge N, at the current `waddr`.
  - `waddr` and `gray_wptr` advance at edge N.
  - `wfull` and `walmost_full` reflect that write from after edge N; no extra cycle.
- Full on the last slot: the write that fills the last slot raises `wfull` in the same edge, so a back-to-back `winc` in cycle N+1 sees `wclken=0`.
- Pointer change rate: `gray_wptr` changes at most one bit per wclk edge.
- Simultaneous write and read-pointer advance: both terms are evaluated in the same cycle.
  - Example: occupancy was DEPTH-1, a write is accepted and `wq2_rptr` advanced by 1 in the same cycle.
  - Required result: `wfull` stays 0 and `walmost_full` stays 1.
- Input handling: `wq2_rptr` is sampled only through combinational compare into flops; no additional synchronization inside this block.

## Test plan
- **Reset mid-stream:** assert `wrst_n`=0 after 5 writes.
  - Required: all outputs 0 immediately, without waiting for a clock.
  - After release, the first write uses `waddr`=0.
- **Fill to full** (pointer_width=4, `wq2_rptr`=0), 8 writes with `winc` held high:
  - `waddr` steps 0..7 and `gray_wptr` steps 0,1,3,2,6,7,5,4,C.
  - `walmost_full`=1 after write 7.
  - `wfull`=1 after write 8; `wclken`=0 in the next cycle.
- **Overflow:** from full, hold `winc`=1 for 3 cycles.
  - Required: `woverflow`=1 and sticky; `waddr` stays 0 and `gray_wptr` stays C.
  - After reset, `woverflow`=0.
- **Wrap:** stream 40 writes with `wq2_rptr` tracking `gray_wptr` delayed 2 cycles.
  - Required: `wfull` never asserts.
  - Binary pointer wraps 15→0 with Gray 8→0.
  - `waddr` wraps every 8 writes.
- **Simultaneous:** with occupancy 7, write and advance `wq2_rptr` by one Gray step in the same cycle.
  - Required: `wfull`=0 and `walmost_full`=1.
- **Drain release:** from full, advance `wq2_rptr` by one step.
  - Required: `wfull` drops on the next edge, and the next write is accepted at `waddr`=0.
